// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect and
// decode handshakes. The fetch unit connects as master, the environment
// (memory, branch unit, decode) connects as slave.
interface ifetch_unit_if;
  logic        imem_req_v_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_resp_v_i;
  logic [31:0] imem_resp_data_i;
  logic        imem_resp_err_i;
  logic        redirect_v_i;
  logic [31:0] redirect_pc_i;
  logic        dec_v_o;
  logic        dec_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fetch_err_o;

  modport master (
    output imem_req_v_o, imem_addr_o, dec_v_o, instr_o, pc_o, fetch_err_o,
    input  imem_req_ready_i, imem_resp_v_i, imem_resp_data_i, imem_resp_err_i,
    input  redirect_v_i, redirect_pc_i, dec_ready_i
  );

  modport slave (
    input  imem_req_v_o, imem_addr_o, dec_v_o, instr_o, pc_o, fetch_err_o,
    output imem_req_ready_i, imem_resp_v_i, imem_resp_data_i, imem_resp_err_i,
    output redirect_v_i, redirect_pc_i, dec_ready_i
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word
// requests, tracks their PCs, queues returned words in order for decode and
// squashes queued/in-flight work on a redirect.
module ifetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          QUEUE_DEPTH  = 4
) (
  input logic         clk,
  input logic         reset_n,
  ifetch_unit_if.master bus
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  // Architectural state
  logic [31:0]   fetch_pc_reg;
  logic [0:0]    state_reg;
  logic [CW-1:0] outst_reg;
  logic [CW-1:0] drop_reg;

  // PC FIFO of in-flight requests
  logic [31:0]   pcf_mem [QUEUE_DEPTH];
  logic [AW-1:0] pcf_wr_reg;
  logic [AW-1:0] pcf_rd_reg;

  // Instruction queue towards decode
  logic [31:0]   q_instr_mem [QUEUE_DEPTH];
  logic [31:0]   q_pc_mem    [QUEUE_DEPTH];
  logic          q_err_mem   [QUEUE_DEPTH];
  logic [AW-1:0] q_head_reg;
  logic [AW-1:0] q_tail_reg;
  logic [CW-1:0] q_count_reg;

  // Handshake / event decode
  logic        credit_ok;
  logic        req_v;
  logic        req_fire;
  logic        resp_take;
  logic        resp_drop;
  logic        push;
  logic        dec_v;
  logic        pop;
  logic        redirect;
  logic [31:0] resp_pc;

  // Event decode: credit check, request gating, response routing, decode pop
  always_comb begin
    redirect  = bus.redirect_v_i;
    credit_ok = ({1'b0, q_count_reg} + {1'b0, outst_reg}) < (CW + 1)'(QUEUE_DEPTH);
    req_v     = reset_n && (state_reg == ST_FETCH) && credit_ok && !redirect;
    req_fire  = req_v && bus.imem_req_ready_i;
    // A response with nothing outstanding cannot be matched to a PC; ignore it
    // rather than corrupt the PC FIFO.
    resp_take = bus.imem_resp_v_i && (outst_reg != '0);
    resp_drop = resp_take && (drop_reg != '0);
    push      = resp_take && (drop_reg == '0) && !redirect;
    dec_v     = reset_n && (q_count_reg != '0);
    pop       = dec_v && bus.dec_ready_i;
    resp_pc   = pcf_mem[pcf_rd_reg];
  end

  // Output drive; head fields are forced to zero whenever nothing is valid
  always_comb begin
    bus.imem_req_v_o = req_v;
    bus.imem_addr_o  = reset_n ? fetch_pc_reg : RESET_VECTOR;
    bus.dec_v_o      = dec_v;
    bus.instr_o      = dec_v ? q_instr_mem[q_head_reg] : 32'h0;
    bus.pc_o         = dec_v ? q_pc_mem[q_head_reg]    : 32'h0;
    bus.fetch_err_o  = dec_v ? q_err_mem[q_head_reg]   : 1'b0;
  end

  // Fetch PC, FSM, outstanding/drop counters and PC FIFO pointers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_reg <= RESET_VECTOR;
      state_reg    <= ST_FETCH;
      outst_reg    <= '0;
      drop_reg     <= '0;
      pcf_wr_reg   <= '0;
      pcf_rd_reg   <= '0;
    end else begin
      if (redirect) begin
        fetch_pc_reg <= bus.redirect_pc_i & 32'hFFFF_FFFC;
      end else if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end

      outst_reg  <= outst_reg + CW'(req_fire) - CW'(resp_take);
      pcf_wr_reg <= pcf_wr_reg + AW'(req_fire);
      pcf_rd_reg <= pcf_rd_reg + AW'(resp_take);

      // Everything still in flight after this cycle belongs to the old stream
      if (redirect) begin
        drop_reg <= outst_reg - CW'(resp_take);
      end else if (resp_drop) begin
        drop_reg <= drop_reg - CW'(1);
      end

      if (redirect) begin
        state_reg <= ST_FETCH;
      end else if (push && bus.imem_resp_err_i) begin
        state_reg <= ST_HALT;
      end
    end
  end

  // Instruction queue pointers and occupancy; a redirect flushes everything
  always_ff @(posedge clk) begin
    if (!reset_n || redirect) begin
      q_head_reg  <= '0;
      q_tail_reg  <= '0;
      q_count_reg <= '0;
    end else begin
      q_tail_reg  <= q_tail_reg + AW'(push);
      q_head_reg  <= q_head_reg + AW'(pop);
      q_count_reg <= q_count_reg + CW'(push) - CW'(pop);
    end
  end

  // Record the PC of each accepted request
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcf_mem[pcf_wr_reg] <= fetch_pc_reg;
    end
  end

  // Store returned words with their PC and fault flag
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr_mem[q_tail_reg] <= bus.imem_resp_data_i;
      q_pc_mem[q_tail_reg]    <= resp_pc;
      q_err_mem[q_tail_reg]   <= bus.imem_resp_err_i;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: behavioural instruction memory with
// configurable latency, an in-order scoreboard of expected decode entries,
// a per-cycle vector table plus directed multi-cycle sequences.
module tb_ifetch_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_unit_if bus0 ();
  ifetch_unit_if bus1 ();

  ifetch_unit #(.RESET_VECTOR(32'h0000_0000), .QUEUE_DEPTH(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.master)
  );
  ifetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.master)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        dr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_dec;
    logic [31:0] exp_pc;
  } vec_t;

  pend_t pend[$];
  exp_t  sb[$];
  vec_t  vecs[14];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample handshakes, advance, update memory model and scoreboard
  task automatic cycle();
    logic acc, pop, rdr;
    logic [31:0] a;
    exp_t e;
    pend_t p;
    #1;
    acc = bus0.imem_req_v_o && bus0.imem_req_ready_i;
    a   = bus0.imem_addr_o;
    rdr = bus0.redirect_v_i;
    pop = bus0.dec_v_o && bus0.dec_ready_i;
    if (pop && !rdr && reset_n) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h expected no entry", bus0.pc_o);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", bus0.pc_o, e.pc);
        chk("sb_instr", bus0.instr_o, e.instr);
        chk("sb_err", {31'b0, bus0.fetch_err_o}, {31'b0, e.err});
        $display("pop pc=%h instr=%h err=%0b", bus0.pc_o, bus0.instr_o, bus0.fetch_err_o);
      end
    end
    @(posedge clk);
    #1;
    if (!reset_n) begin
      pend.delete();
      sb.delete();
    end else begin
      if (rdr) sb.delete();
      if (acc) begin
        p.addr = a;
        p.due  = cyc + lat;
        pend.push_back(p);
        e.pc    = a;
        e.instr = mem_word(a);
        e.err   = err_en && (a == err_addr);
        sb.push_back(e);
      end
    end
    cyc++;
    @(negedge clk);
    bus0.redirect_v_i = 1'b0;
    if (reset_n && pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      bus0.imem_resp_v_i    = 1'b1;
      bus0.imem_resp_data_i = mem_word(p.addr);
      bus0.imem_resp_err_i  = err_en && (p.addr == err_addr);
    end else begin
      bus0.imem_resp_v_i    = 1'b0;
      bus0.imem_resp_data_i = 32'h0;
      bus0.imem_resp_err_i  = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus0.redirect_v_i = 1'b0;
    cycle();
    cycle();
    chk("rst_req_v", {31'b0, bus0.imem_req_v_o}, 32'h0);
    chk("rst_dec_v", {31'b0, bus0.dec_v_o}, 32'h0);
    chk("rst_instr", bus0.instr_o, 32'h0);
    chk("rst_pc", bus0.pc_o, 32'h0);
    chk("rst_err", {31'b0, bus0.fetch_err_o}, 32'h0);
    chk("rst_addr", bus0.imem_addr_o, 32'h0);
    chk("rst_addr_rv", bus1.imem_addr_o, 32'hFFFF_FFF8);
    reset_n = 1'b1;
    cyc = 0;
    $display("reset released");
  endtask

  // Wait (bounded) for the next decode-valid cycle and check its PC
  task automatic wait_dec(input string name, input logic [31:0] exp_pc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (bus0.dec_v_o) begin
        found = 1'b1;
        chk(name, bus0.pc_o, exp_pc);
      end else begin
        cycle();
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no dec_v expected pc %h", name, exp_pc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.imem_req_ready_i = 1'b1;
    bus0.imem_resp_v_i    = 1'b0;
    bus0.imem_resp_data_i = 32'h0;
    bus0.imem_resp_err_i  = 1'b0;
    bus0.redirect_v_i     = 1'b0;
    bus0.redirect_pc_i    = 32'h0;
    bus0.dec_ready_i      = 1'b1;
    bus1.imem_req_ready_i = 1'b1;
    bus1.imem_resp_v_i    = 1'b0;
    bus1.imem_resp_data_i = 32'h0;
    bus1.imem_resp_err_i  = 1'b0;
    bus1.redirect_v_i     = 1'b0;
    bus1.redirect_pc_i    = 32'h0;
    bus1.dec_ready_i      = 1'b0;

    // rst, ready, dec_ready, exp req_v, exp addr, exp dec_v, exp pc
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8};

    @(negedge clk);

    // Startup stream and decode-stall credit limit
    lat = 1;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      bus0.imem_req_ready_i = vecs[i].ready;
      bus0.dec_ready_i      = vecs[i].dr;
      #1;
      chk($sformatf("vec%0d_req_v", i), {31'b0, bus0.imem_req_v_o}, {31'b0, vecs[i].exp_req});
      chk($sformatf("vec%0d_addr", i), bus0.imem_addr_o, vecs[i].exp_addr);
      chk($sformatf("vec%0d_dec_v", i), {31'b0, bus0.dec_v_o}, {31'b0, vecs[i].exp_dec});
      if (vecs[i].exp_dec) chk($sformatf("vec%0d_pc", i), bus0.pc_o, vecs[i].exp_pc);
      cycle();
    end

    // Reset vector near the top of the address space wraps to zero
    do_reset();
    #1;
    chk("rv_addr0", bus1.imem_addr_o, 32'hFFFF_FFF8);
    cycle();
    #1;
    chk("rv_addr1", bus1.imem_addr_o, 32'hFFFF_FFFC);
    cycle();
    #1;
    chk("rv_addr2", bus1.imem_addr_o, 32'h0000_0000);
    chk("rv_req_v2", {31'b0, bus1.imem_req_v_o}, 32'h1);

    // Redirect with two responses still in flight after the redirect cycle
    lat = 3;
    do_reset();
    bus0.imem_req_ready_i = 1'b1;
    bus0.dec_ready_i      = 1'b1;
    cycle();
    cycle();
    cycle();
    bus0.redirect_v_i  = 1'b1;
    bus0.redirect_pc_i = 32'h0000_1002;
    #1;
    chk("redir_req_gated", {31'b0, bus0.imem_req_v_o}, 32'h0);
    cycle();
    #1;
    chk("redir_dec_v_next", {31'b0, bus0.dec_v_o}, 32'h0);
    chk("redir_req_v_next", {31'b0, bus0.imem_req_v_o}, 32'h1);
    chk("redir_addr_next", bus0.imem_addr_o, 32'h0000_1000);
    wait_dec("redir_first_pc", 32'h0000_1000);
    for (int i = 0; i < 4; i++) cycle();

    // Access fault halts fetch until a redirect
    lat = 1;
    err_en = 1'b1;
    err_addr = 32'h8;
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    #1;
    chk("err_dec_v", {31'b0, bus0.dec_v_o}, 32'h1);
    chk("err_pc", bus0.pc_o, 32'h8);
    chk("err_flag", {31'b0, bus0.fetch_err_o}, 32'h1);
    chk("err_req_v", {31'b0, bus0.imem_req_v_o}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      #1;
      chk($sformatf("halt_req_v%0d", i), {31'b0, bus0.imem_req_v_o}, 32'h0);
    end
    err_en = 1'b0;
    bus0.redirect_v_i  = 1'b1;
    bus0.redirect_pc_i = 32'h0000_0100;
    cycle();
    #1;
    chk("halt_resume_req_v", {31'b0, bus0.imem_req_v_o}, 32'h1);
    chk("halt_resume_addr", bus0.imem_addr_o, 32'h0000_0100);
    wait_dec("halt_resume_pc", 32'h0000_0100);
    for (int i = 0; i < 3; i++) cycle();

    // Redirect coincident with a response and a decode pop, then reset mid-stream
    lat = 2;
    do_reset();
    cycle();
    cycle();
    cycle();
    bus0.redirect_v_i  = 1'b1;
    bus0.redirect_pc_i = 32'h0000_0200;
    #1;
    chk("coin_dec_v", {31'b0, bus0.dec_v_o}, 32'h1);
    chk("coin_pc", bus0.pc_o, 32'h0);
    chk("coin_resp_v", {31'b0, bus0.imem_resp_v_i}, 32'h1);
    cycle();
    #1;
    chk("coin_flushed", {31'b0, bus0.dec_v_o}, 32'h0);
    chk("coin_addr", bus0.imem_addr_o, 32'h0000_0200);
    lat = 4;
    for (int i = 0; i < 3; i++) begin
      cycle();
      #1;
      chk($sformatf("coin_dec_v_idle%0d", i), {31'b0, bus0.dec_v_o}, 32'h0);
    end
    lat = 1;
    do_reset();
    #1;
    chk("post_rst_req_v", {31'b0, bus0.imem_req_v_o}, 32'h1);
    chk("post_rst_addr", bus0.imem_addr_o, 32'h0);
    chk("post_rst_dec_v", {31'b0, bus0.dec_v_o}, 32'h0);
    wait_dec("post_rst_first_pc", 32'h0);
    for (int i = 0; i < 4; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage. Produces the instruction word and PC pair that the decode stage consumes.
- Holds the architectural fetch PC and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned words in a small in-order queue and presents them to decode over a valid/ready handshake.
- Handles redirects (branch, jump, trap) by flushing the queue and discarding responses still in flight.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- QUEUE_DEPTH, 4, instruction queue entries; power of two, minimum 2.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- imem_req_v_o  output  1  fetch request valid
- imem_req_ready_i  input  1  memory accepts the request this cycle
- imem_addr_o  output  32  word address; bits [1:0] always 0
- imem_resp_v_i  input  1  response valid; in request order; earliest one cycle after acceptance
- imem_resp_data_i  input  32  instruction word
- imem_resp_err_i  input  1  access fault for this response
- redirect_v_i  input  1  redirect fetch
- redirect_pc_i  input  32  new PC; bits [1:0] ignored and forced to 0
- dec_v_o  output  1  queue head valid
- dec_ready_i  input  1  decode consumes the head this cycle
- instr_o  output  32  head instruction word
- pc_o  output  32  head instruction PC
- fetch_err_o  output  1  head entry carries an access fault

Behaviour:
- Reset is synchronous and active-low: when reset_n=0 at a clk edge, all state clears.
  - fetch_pc=RESET_VECTOR, queue empty, outstanding=0, drop=0, FSM=FETCH.
  - Outputs during and after reset: imem_req_v_o=0, dec_v_o=0, instr_o=0, pc_o=0, fetch_err_o=0.
  - imem_addr_o=RESET_VECTOR.
  - Reset mid-operation abandons all in-flight requests. Responses arriving after reset deasserts while drop=0 are treated as new; the memory side is reset together with this block.
- FSM states:
  - FETCH: imem_req_v_o=1 iff (occupancy + outstanding) < QUEUE_DEPTH and redirect_v_i=0.
  - HALT: imem_req_v_o=0. Entered when an accepted (non-dropped) response has err=1. Left only by a redirect, which returns to FETCH.
- Request acceptance occurs when imem_req_v_o && imem_req_ready_i:
  - fetch_pc += 4, with 32-bit wrap-around (FFFF_FFFC -> 0000_0000).
  - outstanding += 1.
  - The PC of each in-flight request is kept in a QUEUE_DEPTH-entry PC FIFO; this FIFO cannot overflow thanks to the credit rule.
  - imem_addr_o = fetch_pc, and stays stable while imem_req_v_o=1 and ready=0.
- Response handling, when imem_resp_v_i=1:
  - outstanding -= 1; pop the PC FIFO.
  - If drop>0: drop -= 1 and discard the response.
  - Otherwise: push {data, pc, err} into the queue; if err=1, FSM -> HALT.
- Decode side:
  - dec_v_o = queue not empty; instr_o, pc_o and fetch_err_o show the head.
  - Pop on dec_v_o && dec_ready_i.
  - Head outputs stay stable while dec_v_o=1 and dec_ready_i=0.
  - The queue accepts a push and a pop in the same cycle, including when full; the credit rule guarantees there is never a push into a full queue without a pop.
  - Minimum latency: request accepted at cycle N, response at N+1, dec_v_o=1 at N+2 (registered queue, no bypass).
- Redirect (redirect_v_i=1 at an edge) has priority over every other event in that cycle:
  - Queue flushed; any pop in that cycle is ignored for occupancy purposes.
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}; FSM -> FETCH.
  - drop = outstanding (after this cycle's response decrement; no request is accepted in this cycle because req_v is gated).
  - A response arriving in the redirect cycle is discarded.
  - dec_v_o=0 in the cycle after the redirect.
  - First new request is issued in the next cycle.
- Back-to-back redirects: the last one wins; drop is recomputed each time.
- Invariants: drop <= outstanding <= QUEUE_DEPTH; occupancy + outstanding <= QUEUE_DEPTH.

Test Plan:
- Reset, memory always ready, 1-cycle response, decode always ready:
  - imem_addr_o = 0,4,8,C on consecutive cycles.
  - dec_v_o rises at cycle 3 after reset release with pc_o=0; then one instruction per cycle with matching words.
- Decode stalled (dec_ready_i=0), QUEUE_DEPTH=4:
  - Exactly 4 requests accepted, then imem_req_v_o=0.
  - Head holds pc_o=0 steady.
  - Release ready -> one new request per pop; no loss or duplication.
- Redirect to 0x0000_1002 with 2 responses in flight:
  - Next request address is 0x0000_1000.
  - The 2 stale responses are discarded.
  - First dec_v_o after the redirect shows pc_o=0x1000.
- Response with imem_resp_err_i=1 at pc 0x8:
  - Entry delivered with fetch_err_o=1, pc_o=0x8.
  - imem_req_v_o stays 0 until redirect to 0x100; fetch then resumes at 0x100.
- RESET_VECTOR=32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Redirect coincident with response and decode pop, then reset_n=0 mid-stream with 3 in flight:
  - Queue empty next cycle; no stale entry ever reaches decode.
  - After reset, fetch restarts at RESET_VECTOR with all outputs at their reset values.
